// File: rtl/pipelined_adder_if.sv
// Valid/ready stream bundle for the sliced pipelined adder.
// Operand beats enter on one side and result beats leave on the other.
interface pipelined_adder_if #(
    parameter int Width = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] a;
    logic [Width-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor built from Stages equal slices, one slice per stage.
// The carry is registered between stages, so no carry chain spans more than Width/Stages bits.
module pipelined_adder #(
    parameter int Width  = 32,
    parameter int Stages = 4
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);
    localparam int SW   = Width / Stages;
    localparam int Last = Stages - 1;

    if (Stages < 1 || Stages > Width || (Width % Stages) != 0) begin : g_bad_params
        $error("pipelined_adder: Width must be a multiple of Stages, with 1 <= Stages <= Width");
    end

    logic [Width-1:0] a_q [Stages];
    logic [Width-1:0] b_q [Stages];
    logic [Width-1:0] s_q [Stages];
    logic             c_q [Stages];
    logic             v_q [Stages];

    logic [Width-1:0] a_d [Stages];
    logic [Width-1:0] b_d [Stages];
    logic [Width-1:0] s_d [Stages];
    logic             c_d [Stages];
    logic             v_d [Stages];

    logic             ready [Stages];

    function automatic logic [SW:0] add_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                              input logic c);
        return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, c};
    endfunction

    // A stage may load if it is empty or anything downstream of it can move.
    always_comb begin
        logic downstream;
        downstream = bus.out_ready;
        for (int k = Last; k >= 0; k--) begin
            ready[k]   = ~v_q[k] | downstream;
            downstream = ready[k];
        end
    end

    always_comb begin
        logic [SW:0] slice;
        a_d[0]         = bus.a;
        b_d[0]         = bus.sub ? ~bus.b : bus.b;
        s_d[0]         = '0;
        slice          = add_slice(bus.a[SW-1:0], b_d[0][SW-1:0], bus.sub ? 1'b1 : bus.cin);
        s_d[0][SW-1:0] = slice[SW-1:0];
        c_d[0]         = slice[SW];
        v_d[0]         = bus.in_valid;
        // Later stages add their own slice and forward everything else untouched.
        for (int k = 1; k < Stages; k++) begin
            a_d[k]              = a_q[k-1];
            b_d[k]              = b_q[k-1];
            s_d[k]              = s_q[k-1];
            slice               = add_slice(a_q[k-1][k*SW +: SW], b_q[k-1][k*SW +: SW], c_q[k-1]);
            s_d[k][k*SW +: SW]  = slice[SW-1:0];
            c_d[k]              = slice[SW];
            v_d[k]              = v_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < Stages; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < Stages; k++) begin
                if (ready[k]) begin
                    v_q[k] <= v_d[k];
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
        end
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = v_q[Last];
    assign bus.sum       = s_q[Last];
    assign bus.cout      = c_q[Last];
    // Same-sign operands producing a result of the other sign.
    assign bus.ovf       = (a_q[Last][Width-1] == b_q[Last][Width-1]) &&
                           (s_q[Last][Width-1] != a_q[Last][Width-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder in three shapes (32/4, 16/1, 8/8), scored against a plain
// integer add/subtract model with an in-order queue of expected results per instance.
module tb_pipelined_adder;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } beat_t;

    localparam int NumDut = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        drv_valid  [NumDut];
    logic        drv_cin    [NumDut];
    logic        drv_sub    [NumDut];
    logic        drv_oready [NumDut];
    logic [31:0] drv_a      [NumDut];
    logic [31:0] drv_b      [NumDut];
    logic        mon_iready [NumDut];
    logic        mon_ovalid [NumDut];
    logic        mon_cout   [NumDut];
    logic        mon_ovf    [NumDut];
    logic [31:0] mon_sum    [NumDut];

    pipelined_adder_if #(.Width(32)) bus0 ();
    pipelined_adder_if #(.Width(16)) bus1 ();
    pipelined_adder_if #(.Width(8))  bus2 ();

    pipelined_adder #(.Width(32), .Stages(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    pipelined_adder #(.Width(16), .Stages(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    pipelined_adder #(.Width(8),  .Stages(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    assign bus0.in_valid  = drv_valid[0];
    assign bus0.a         = drv_a[0];
    assign bus0.b         = drv_b[0];
    assign bus0.cin       = drv_cin[0];
    assign bus0.sub       = drv_sub[0];
    assign bus0.out_ready = drv_oready[0];
    assign mon_iready[0]  = bus0.in_ready;
    assign mon_ovalid[0]  = bus0.out_valid;
    assign mon_sum[0]     = bus0.sum;
    assign mon_cout[0]    = bus0.cout;
    assign mon_ovf[0]     = bus0.ovf;

    assign bus1.in_valid  = drv_valid[1];
    assign bus1.a         = drv_a[1][15:0];
    assign bus1.b         = drv_b[1][15:0];
    assign bus1.cin       = drv_cin[1];
    assign bus1.sub       = drv_sub[1];
    assign bus1.out_ready = drv_oready[1];
    assign mon_iready[1]  = bus1.in_ready;
    assign mon_ovalid[1]  = bus1.out_valid;
    assign mon_sum[1]     = {16'h0, bus1.sum};
    assign mon_cout[1]    = bus1.cout;
    assign mon_ovf[1]     = bus1.ovf;

    assign bus2.in_valid  = drv_valid[2];
    assign bus2.a         = drv_a[2][7:0];
    assign bus2.b         = drv_b[2][7:0];
    assign bus2.cin       = drv_cin[2];
    assign bus2.sub       = drv_sub[2];
    assign bus2.out_ready = drv_oready[2];
    assign mon_iready[2]  = bus2.in_ready;
    assign mon_ovalid[2]  = bus2.out_valid;
    assign mon_sum[2]     = {24'h0, bus2.sum};
    assign mon_cout[2]    = bus2.cout;
    assign mon_ovf[2]     = bus2.ovf;

    int    vectors     = 0;
    int    miscompares = 0;
    int    checks      = 0;
    beat_t exp_q [NumDut][$];

    function automatic int wid_of(input int id);
        case (id)
            0:       return 32;
            1:       return 16;
            default: return 8;
        endcase
    endfunction

    function automatic int stg_of(input int id);
        case (id)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    // Result of a w-bit add or subtract, from ordinary integer arithmetic.
    function automatic beat_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sub);
        beat_t  r;
        longint lim, ua, ub, sa, sb, c, res, sres;
        lim = longint'(1) << w;
        ua  = longint'(a) & (lim - 1);
        ub  = longint'(b) & (lim - 1);
        sa  = (ua >= lim / 2) ? ua - lim : ua;
        sb  = (ub >= lim / 2) ? ub - lim : ub;
        c   = cin ? 1 : 0;
        if (sub) begin
            res    = ua - ub;
            sres   = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            res    = ua + ub + c;
            sres   = sa + sb + c;
            r.cout = (res >= lim);
        end
        r.sum = 32'(res & (lim - 1));
        r.ovf = (sres >= lim / 2) || (sres < -(lim / 2));
        return r;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic scoreboard(input int id);
        beat_t e;
        check_output($sformatf("dut%0d in_ready", id), 64'(mon_iready[id]),
                     64'(drv_oready[id] || (exp_q[id].size() < stg_of(id))));
        if (mon_ovalid[id]) begin
            if (exp_q[id].size() == 0) begin
                check_output($sformatf("dut%0d out_valid with nothing in flight", id),
                             64'(mon_ovalid[id]), 64'(0));
            end else begin
                e = exp_q[id][0];
                check_output($sformatf("dut%0d sum", id), 64'(mon_sum[id]), 64'(e.sum));
                check_output($sformatf("dut%0d cout", id), 64'(mon_cout[id]), 64'(e.cout));
                check_output($sformatf("dut%0d ovf", id), 64'(mon_ovf[id]), 64'(e.ovf));
                if (drv_oready[id]) void'(exp_q[id].pop_front());
            end
        end
        if (drv_valid[id] && mon_iready[id]) begin
            exp_q[id].push_back(model(wid_of(id), drv_a[id], drv_b[id], drv_cin[id], drv_sub[id]));
            vectors++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NumDut; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < NumDut; i++) scoreboard(i);
        end
    end

    // Offer one beat and hold it until it is taken; returns just after the accepting edge.
    task automatic apply_stimulus(input int id, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub);
        int waited;
        waited          = 0;
        drv_a[id]       = a;
        drv_b[id]       = b;
        drv_cin[id]     = cin;
        drv_sub[id]     = sub;
        drv_valid[id]   = 1'b1;
        @(negedge clk);
        while (!mon_iready[id] && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 200)
            check_output($sformatf("dut%0d accept timeout", id), 64'(mon_iready[id]), 64'(1));
        @(posedge clk);
        #1;
        drv_valid[id] = 1'b0;
    endtask

    task automatic directed(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub, input logic [31:0] exp_sum,
                            input logic exp_cout, input logic exp_ovf);
        int lat;
        lat             = 0;
        drv_oready[id]  = 1'b1;
        drv_a[id]       = a;
        drv_b[id]       = b;
        drv_cin[id]     = cin;
        drv_sub[id]     = sub;
        drv_valid[id]   = 1'b1;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1 drv_valid[id] = 1'b0;
            @(negedge clk);
            if (mon_ovalid[id]) break;
        end
        check_output($sformatf("dut%0d latency", id), 64'(lat), 64'(stg_of(id)));
        check_output($sformatf("dut%0d literal sum", id), 64'(mon_sum[id]), 64'(exp_sum));
        check_output($sformatf("dut%0d literal cout", id), 64'(mon_cout[id]), 64'(exp_cout));
        check_output($sformatf("dut%0d literal ovf", id), 64'(mon_ovf[id]), 64'(exp_ovf));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: run still active at 600000, expected to finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit done;
        for (int i = 0; i < NumDut; i++) begin
            drv_valid[i]  = 1'b0;
            drv_a[i]      = '0;
            drv_b[i]      = '0;
            drv_cin[i]    = 1'b0;
            drv_sub[i]    = 1'b0;
            drv_oready[i] = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        check_output("reset out_valid", 64'(mon_ovalid[0]), 64'(0));
        check_output("reset sum", 64'(mon_sum[0]), 64'(0));
        check_output("reset cout", 64'(mon_cout[0]), 64'(0));
        check_output("reset ovf", 64'(mon_ovf[0]), 64'(0));
        check_output("reset out_valid dut2", 64'(mon_ovalid[2]), 64'(0));

        check_output("model add wrap", 64'(model(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0)),
                     64'({32'h0, 1'b1, 1'b0}));
        check_output("model add ovf", 64'(model(8, 32'h7F, 32'h1, 1'b0, 1'b0)),
                     64'({32'h80, 1'b0, 1'b1}));
        check_output("model sub borrow", 64'(model(16, 32'h3, 32'h5, 1'b1, 1'b1)),
                     64'({32'hFFFE, 1'b0, 1'b0}));
        check_output("model sub ovf", 64'(model(8, 32'h80, 32'h1, 1'b0, 1'b1)),
                     64'({32'h7F, 1'b1, 1'b1}));

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NumDut; i++)
            check_output($sformatf("dut%0d in_ready after reset", i), 64'(mon_iready[i]), 64'(1));
        @(posedge clk);
        #1;

        directed(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed(1, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_8000, 1'b0, 1'b1);

        // Fill the 4-stage pipe with the consumer stalled, then release it while still feeding.
        drv_oready[0] = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus(0, 32'(i), 32'(i) << 8, 1'b0, 1'b0);
        drv_a[0]     = 32'd4;
        drv_b[0]     = 32'd4 << 8;
        drv_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("full in_ready", 64'(mon_iready[0]), 64'(0));
            check_output("held out_valid", 64'(mon_ovalid[0]), 64'(1));
            check_output("held sum beat0", 64'(mon_sum[0]), 64'(0));
        end
        @(posedge clk);
        #1 drv_oready[0] = 1'b1;
        fork
            for (int i = 4; i < 8; i++) apply_stimulus(0, 32'(i), 32'(i) << 8, 1'b0, 1'b0);
            repeat (8) begin
                @(negedge clk);
                check_output("stream out_valid", 64'(mon_ovalid[0]), 64'(1));
                check_output("stream in_ready", 64'(mon_iready[0]), 64'(1));
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check_output("stream drained", 64'(exp_q[0].size()), 64'(0));

        // Leave non-zero junk in the idle stages, then reset with three beats in flight.
        drv_a[0] = 32'hDEAD_BEEF;
        drv_b[0] = 32'h1234_5678;
        repeat (6) @(posedge clk);
        #1;
        apply_stimulus(0, 32'hCAFE_0001, 32'h0F0F_0F0F, 1'b1, 1'b0);
        apply_stimulus(0, 32'h8765_4321, 32'h1111_1111, 1'b0, 1'b1);
        apply_stimulus(0, 32'hFFFF_0000, 32'h0001_FFFF, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_output("mid reset out_valid", 64'(mon_ovalid[0]), 64'(0));
        check_output("mid reset sum", 64'(mon_sum[0]), 64'(0));
        check_output("mid reset cout", 64'(mon_cout[0]), 64'(0));
        check_output("mid reset ovf", 64'(mon_ovf[0]), 64'(0));
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_output("no stale beat", 64'(mon_ovalid[0]), 64'(0));
        end
        @(posedge clk);
        #1;

        done = 1'b0;
        fork
            begin
                fork
                    for (int n = 0; n < 1000; n++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        apply_stimulus(2, $urandom, $urandom, 1'($urandom_range(0, 1)),
                                       1'($urandom_range(0, 1)));
                    end
                    for (int n = 0; n < 300; n++)
                        apply_stimulus(0, $urandom, $urandom, 1'($urandom_range(0, 1)),
                                       1'($urandom_range(0, 1)));
                    for (int n = 0; n < 200; n++)
                        apply_stimulus(1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                                       1'($urandom_range(0, 1)));
                join
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk);
                #1;
                drv_oready[0] = ($urandom_range(0, 3) != 0);
                drv_oready[1] = ($urandom_range(0, 2) != 0);
                drv_oready[2] = 1'($urandom_range(0, 1));
            end
        join

        for (int i = 0; i < NumDut; i++) drv_oready[i] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < NumDut; i++)
            check_output($sformatf("dut%0d final drain", i), 64'(exp_q[i].size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
